dial_stream_sequencer: RTL and testbench
========================================

Name: dial_stream_sequencer

Overview:
- Sequences the dial-rotation zero-counting processor from a raw ASCII puzzle stream, e.g. "L68\nR48\n".
- Handles the input byte handshake and parses one rotation per line into a {direction, magnitude} packet.
- Issues the processor's reset and single-cycle valid pulses, and flags completion once the final count is stable.
- Sits between the input byte source (UART/FIFO) and the processor; the processor's answer is read directly by the host after o_done.

Parameters:
- VAL_W, 31, magnitude width; must equal the processor's packet width minus 1.
- FLUSH_CYC, 1, cycles between the last o_dataValid pulse and o_done assertion.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  begin a new run; sampled in IDLE and DONE only.
- i_byte  in  8  ASCII input byte.
- i_byteValid  in  1  i_byte is valid.
- i_byteLast  in  1  qualifies the final byte of the stream.
- o_byteReady  out  1  byte accepted when i_byteValid && o_byteReady.
- o_procRst  out  1  synchronous active-high reset to the processor.
- o_dataValid  out  1  single-cycle packet strobe to the processor.
- o_packet  out  VAL_W+1  bit[VAL_W] = direction (1 = R, 0 = L); bits[VAL_W-1:0] = magnitude.
- o_busy  out  1  high in RESET, RUN and FLUSH.
- o_done  out  1  sticky; the processor answer is final.
- o_error  out  1  sticky; malformed input or magnitude saturation seen.

Behaviour:
- Async reset values: state=IDLE; o_byteReady=0; o_procRst=0; o_dataValid=0; o_packet=0; o_busy=0; o_done=0; o_error=0; internal accumulator, direction, digit flag and discard flag all 0.
- Outputs are registered. o_byteReady is high only in RUN.
- IDLE: on i_start, go to RESET.
- DONE: on i_start, go to RESET and clear o_done and o_error in the same edge.
- RESET: o_procRst=1 for exactly one cycle, then go to RUN. i_start is ignored in all other states.
- RUN, per accepted byte:
  - 'L' (0x4C) / 'R' (0x52): load direction (0/1), clear accumulator and digit flag. Only legal as the first character of a line; elsewhere it is malformed.
  - '0'-'9': acc = acc*10 + digit, set digit flag. If the result exceeds 2^VAL_W-1, saturate to 2^VAL_W-1 and set o_error.
  - '\n' (0x0A): if the line held a direction and at least one digit, emit the packet. Always reset per-line state and clear the discard flag.
  - '\r' (0x0D): ignored.
  - Empty or whitespace-only lines: no packet.
  - Any other byte, a digit before a direction, or a second direction letter: set o_error and the discard flag. Subsequent bytes up to and including the next '\n' are consumed without emitting a packet.
- Emit timing: the byte is accepted at edge N; o_dataValid=1 with a stable o_packet for the cycle after N only. o_packet holds its value after the pulse.
- Back-to-back lines: at most one packet per line, and a line is at least 2 bytes, so pulses are never adjacent. No output stall is needed.
- i_byteLast: on acceptance of the last byte, emit any pending complete line, even without a trailing '\n'. Then go to FLUSH; o_byteReady drops the cycle after.
- FLUSH: count FLUSH_CYC cycles after the final o_dataValid (or after the last byte if no packet was emitted), then go to DONE with o_done=1.
- DONE: o_busy=0 and o_byteReady=0. o_done stays high until i_start or reset.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. The processor is not re-reset until the next i_start.
- Bytes presented outside RUN are not accepted and are not lost; they are held by the source.

Optional Feature:
- Macro: DIAL_SEQ_STATS_EN.
- Defined: adds two outputs, o_lineCount (32, packets emitted) and o_discardCount (16, lines discarded).
  - Both clear on async reset and on RESET entry.
  - o_lineCount increments on each o_dataValid; o_discardCount increments when a discarded line's '\n' or the last byte is consumed.
  - Both saturate at all-ones.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, pulse i_start, stream "L68\nL30\nR48\n" with i_byteLast on the final '\n' -> o_procRst pulses once; three o_dataValid pulses with o_packet = {0,68}, {0,30}, {1,48}; o_done rises FLUSH_CYC cycles after the third pulse; o_error=0.
- Stream "R1000" with no newline, i_byteLast on the final '0' -> one packet {1,1000}; o_done follows.
- Stream "L5\nX9\n\nR7\n" -> packets {0,5} and {1,7} only; o_error=1; with DIAL_SEQ_STATS_EN, o_lineCount=2 and o_discardCount=1.
- Stream "R99999999999\n" -> one packet {1,2^31-1}; o_error=1.
- Random i_byteValid gaps, CR/LF line endings ("L2\r\nR3\r\n") -> packets {0,2} and {1,3}; no extra pulses; no byte lost or duplicated.
- Deassert rst_n mid-line in RUN, release, then pulse i_start -> outputs return to reset values immediately; the new run starts with an o_procRst pulse; o_done and o_error are cleared and the stale partial line is not emitted.

Source files
------------

// File: rtl/dial_stream_sequencer.sv
// dial_stream_sequencer
// Parses a raw ASCII rotation stream ("L68\nR48\n...") into {direction, magnitude}
// packets and sequences the zero-counting processor: one reset pulse per run,
// one single-cycle valid strobe per complete line, and a sticky done flag once the
// processor's count has settled.
// Optional build macro: DIAL_SEQ_STATS_EN adds o_lineCount / o_discardCount.

module dial_stream_sequencer #(
    parameter int VAL_W     = 31,
    parameter int FLUSH_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_byte,
    input  logic             i_byteValid,
    input  logic             i_byteLast,
    output logic             o_byteReady,
    output logic             o_procRst,
    output logic             o_dataValid,
    output logic [VAL_W:0]   o_packet,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error
`ifdef DIAL_SEQ_STATS_EN
    ,
    output logic [31:0]      o_lineCount,
    output logic [15:0]      o_discardCount
`endif
);

    localparam int ACC_W  = VAL_W + 4;
    localparam int FCNT_W = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
    localparam logic [VAL_W-1:0] ACC_MAX = '1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RESET = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              byteReady_q, byteReady_d;
    logic              procRst_q, procRst_d;
    logic              dataValid_q, dataValid_d;
    logic [VAL_W:0]    packet_q, packet_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [VAL_W-1:0]  acc_q, acc_d;
    logic              dir_q, dir_d;
    logic              hasDir_q, hasDir_d;
    logic              digit_q, digit_d;
    logic              discard_q, discard_d;
    logic [FCNT_W-1:0] flushCnt_q, flushCnt_d;

    logic              isDirL, isDirR, isDigit, isLf, isCr;
    logic              byteAccept;
    logic              startReq;
    logic [ACC_W-1:0]  accWide;
    logic              accOvf;
    logic [VAL_W-1:0]  accSat;

    assign isDirL     = (i_byte == 8'h4C);
    assign isDirR     = (i_byte == 8'h52);
    assign isDigit    = (i_byte >= 8'h30) && (i_byte <= 8'h39);
    assign isLf       = (i_byte == 8'h0A);
    assign isCr       = (i_byte == 8'h0D);
    assign byteAccept = byteReady_q && i_byteValid;
    assign startReq   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && i_start;

    // Decimal accumulate with headroom so an overflow past the magnitude width is visible
    assign accWide = ({4'b0000, acc_q} * ACC_W'(10)) + ACC_W'(i_byte[3:0]);
    assign accOvf  = |accWide[ACC_W-1:VAL_W];
    assign accSat  = accOvf ? ACC_MAX : accWide[VAL_W-1:0];

    // Next-state logic: run sequencing plus the per-byte line parser
    always_comb begin
        state_d     = state_q;
        byteReady_d = byteReady_q;
        procRst_d   = 1'b0;
        dataValid_d = 1'b0;
        packet_d    = packet_q;
        done_d      = done_q;
        error_d     = error_q;
        acc_d       = acc_q;
        dir_d       = dir_q;
        hasDir_d    = hasDir_q;
        digit_d     = digit_q;
        discard_d   = discard_q;
        flushCnt_d  = flushCnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (startReq) begin
                    state_d   = ST_RESET;
                    procRst_d = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    acc_d     = '0;
                    dir_d     = 1'b0;
                    hasDir_d  = 1'b0;
                    digit_d   = 1'b0;
                    discard_d = 1'b0;
                end
            end

            ST_RESET: begin
                state_d     = ST_RUN;
                byteReady_d = 1'b1;
            end

            ST_RUN: begin
                if (byteAccept) begin
                    if (discard_q) begin
                        if (isLf) begin
                            acc_d     = '0;
                            hasDir_d  = 1'b0;
                            digit_d   = 1'b0;
                            discard_d = 1'b0;
                        end
                    end else if (isLf) begin
                        if (hasDir_q && digit_q) begin
                            dataValid_d = 1'b1;
                            packet_d    = {dir_q, acc_q};
                        end
                        acc_d    = '0;
                        hasDir_d = 1'b0;
                        digit_d  = 1'b0;
                    end else if (isCr) begin
                        acc_d = acc_q;
                    end else if (isDirL || isDirR) begin
                        if (!hasDir_q && !digit_q) begin
                            dir_d    = isDirR;
                            hasDir_d = 1'b1;
                            acc_d    = '0;
                            digit_d  = 1'b0;
                        end else begin
                            error_d   = 1'b1;
                            discard_d = 1'b1;
                        end
                    end else if (isDigit) begin
                        if (!hasDir_q) begin
                            error_d   = 1'b1;
                            discard_d = 1'b1;
                        end else begin
                            acc_d   = accSat;
                            digit_d = 1'b1;
                            if (accOvf) begin
                                error_d = 1'b1;
                            end
                        end
                    end else begin
                        error_d   = 1'b1;
                        discard_d = 1'b1;
                    end

                    if (i_byteLast) begin
                        if (!isLf && !discard_d && hasDir_d && digit_d) begin
                            dataValid_d = 1'b1;
                            packet_d    = {dir_d, acc_d};
                        end
                        state_d     = ST_FLUSH;
                        byteReady_d = 1'b0;
                        flushCnt_d  = FCNT_W'(FLUSH_CYC);
                    end
                end
            end

            ST_FLUSH: begin
                if (flushCnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    flushCnt_d = flushCnt_q - FCNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                byteReady_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_FLUSH);
    end

    // State and registered outputs; reset drops everything straight back to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byteReady_q <= 1'b0;
            procRst_q   <= 1'b0;
            dataValid_q <= 1'b0;
            packet_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            acc_q       <= '0;
            dir_q       <= 1'b0;
            hasDir_q    <= 1'b0;
            digit_q     <= 1'b0;
            discard_q   <= 1'b0;
            flushCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            byteReady_q <= byteReady_d;
            procRst_q   <= procRst_d;
            dataValid_q <= dataValid_d;
            packet_q    <= packet_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            acc_q       <= acc_d;
            dir_q       <= dir_d;
            hasDir_q    <= hasDir_d;
            digit_q     <= digit_d;
            discard_q   <= discard_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign o_byteReady = byteReady_q;
    assign o_procRst   = procRst_q;
    assign o_dataValid = dataValid_q;
    assign o_packet    = packet_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_error     = error_q;

`ifdef DIAL_SEQ_STATS_EN
    logic [31:0] lineCnt_q, lineCnt_d;
    logic [15:0] discCnt_q, discCnt_d;
    logic        lineDisc;

    // A line is counted as discarded when its terminating newline or the stream's last byte lands
    assign lineDisc = (state_q == ST_RUN) && byteAccept &&
                      ((isLf && discard_q) || (i_byteLast && !isLf && discard_d));

    // Saturating statistics, restarted with every new run
    always_comb begin
        lineCnt_d = lineCnt_q;
        discCnt_d = discCnt_q;
        if (startReq) begin
            lineCnt_d = '0;
            discCnt_d = '0;
        end else begin
            if (dataValid_d && (lineCnt_q != '1)) begin
                lineCnt_d = lineCnt_q + 32'd1;
            end
            if (lineDisc && (discCnt_q != '1)) begin
                discCnt_d = discCnt_q + 16'd1;
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lineCnt_q <= '0;
            discCnt_q <= '0;
        end else begin
            lineCnt_q <= lineCnt_d;
            discCnt_q <= discCnt_d;
        end
    end

    assign o_lineCount    = lineCnt_q;
    assign o_discardCount = discCnt_q;
`endif

endmodule

// File: tb/tb_dial_stream_sequencer.sv
// tb_dial_stream_sequencer
// Directed bench for dial_stream_sequencer: streams ASCII rotation text and
// compares emitted packets, flags and timing against hand-computed values.

module tb_dial_stream_sequencer;

    localparam int VAL_W     = 31;
    localparam int FLUSH_CYC = 1;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [7:0]        i_byte;
    logic              i_byteValid;
    logic              i_byteLast;
    logic              o_byteReady;
    logic              o_procRst;
    logic              o_dataValid;
    logic [VAL_W:0]    o_packet;
    logic              o_busy;
    logic              o_done;
    logic              o_error;
`ifdef DIAL_SEQ_STATS_EN
    logic [31:0]       o_lineCount;
    logic [15:0]       o_discardCount;
`endif

    int assertions;
    int failures;

    int          cyc;
    int          rstPulses;
    int          adjacentPulses;
    int          lastValidCyc;
    int          doneRiseCyc;
    logic        prevValid;
    logic        prevDone;
    logic [31:0] pktQ[$];

    dial_stream_sequencer #(
        .VAL_W     (VAL_W),
        .FLUSH_CYC (FLUSH_CYC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_byte         (i_byte),
        .i_byteValid    (i_byteValid),
        .i_byteLast     (i_byteLast),
        .o_byteReady    (o_byteReady),
        .o_procRst      (o_procRst),
        .o_dataValid    (o_dataValid),
        .o_packet       (o_packet),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_error        (o_error)
`ifdef DIAL_SEQ_STATS_EN
        ,
        .o_lineCount    (o_lineCount),
        .o_discardCount (o_discardCount)
`endif
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive monitor: records packets, reset pulses and done timing mid-cycle
    initial begin
        cyc = 0; rstPulses = 0; adjacentPulses = 0;
        lastValidCyc = 0; doneRiseCyc = 0;
        prevValid = 1'b0; prevDone = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (o_procRst === 1'b1) rstPulses = rstPulses + 1;
            if (o_dataValid === 1'b1) begin
                pktQ.push_back(o_packet);
                lastValidCyc = cyc;
                if (prevValid === 1'b1) adjacentPulses = adjacentPulses + 1;
            end
            if ((o_done === 1'b1) && (prevDone !== 1'b1)) doneRiseCyc = cyc;
            prevValid = o_dataValid;
            prevDone  = o_done;
        end
    end

    function automatic logic [31:0] getPkt(input int idx);
        if (idx < pktQ.size()) return pktQ[idx];
        return 32'hxxxxxxxx;
    endfunction

    task automatic startRun();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic sendBytes(input string s, input bit gaps, input bit last);
        int t;
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            i_byte      = s[i];
            i_byteValid = 1'b1;
            i_byteLast  = last && (i == s.len() - 1);
            t = 0;
            while ((o_byteReady !== 1'b1) && (t < 50)) begin
                @(negedge clk);
                t++;
            end
            if (o_byteReady !== 1'b1) begin
                assertions++; failures++;
                $display("[TB] FAIL handshake_timeout: byte index %0d ready=%b required 1", i, o_byteReady);
            end
            @(negedge clk);
            i_byteValid = 1'b0;
            i_byteLast  = 1'b0;
        end
    endtask

    task automatic waitDone(input string name);
        int t;
        t = 0;
        while ((o_done !== 1'b1) && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        assertions++;
        if (o_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s_done_timeout: o_done=%b required 1", name, o_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_start = 1'b0; i_byte = 8'h00; i_byteValid = 1'b0; i_byteLast = 1'b0;
        repeat (2) @(negedge clk);
        assertions++;
        if ({o_byteReady, o_procRst, o_dataValid, o_busy, o_done, o_error} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b required 000000",
                     {o_byteReady, o_procRst, o_dataValid, o_busy, o_done, o_error});
        end
        assertions++;
        if (o_packet !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_packet: got %h required 00000000", o_packet);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        assertions++;
        if ((o_busy !== 1'b0) || (o_byteReady !== 1'b0)) begin
            failures++;
            $display("[TB] FAIL idle_no_start: busy=%b ready=%b required 0 0", o_busy, o_byteReady);
        end
    endtask

    task automatic test_basic();
        int base, rbase;
        base = pktQ.size(); rbase = rstPulses;
        startRun();
        assertions++;
        if ((o_procRst !== 1'b1) || (o_busy !== 1'b1)) begin
            failures++;
            $display("[TB] FAIL basic_reset_state: procRst=%b busy=%b required 1 1", o_procRst, o_busy);
        end
        sendBytes("L68\nL30\nR48\n", 1'b0, 1'b1);
        assertions++;
        if (o_byteReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_ready_drop: got %b required 0", o_byteReady);
        end
        waitDone("basic");
        assertions++;
        if (rstPulses - rbase != 1) begin
            failures++;
            $display("[TB] FAIL basic_procrst_count: got %0d required 1", rstPulses - rbase);
        end
        assertions++;
        if (pktQ.size() - base != 3) begin
            failures++;
            $display("[TB] FAIL basic_pkt_count: got %0d required 3", pktQ.size() - base);
        end
        assertions++;
        if (getPkt(base) !== {1'b0, 31'd68}) begin
            failures++;
            $display("[TB] FAIL basic_pkt0: got %h required %h", getPkt(base), {1'b0, 31'd68});
        end
        assertions++;
        if (getPkt(base + 1) !== {1'b0, 31'd30}) begin
            failures++;
            $display("[TB] FAIL basic_pkt1: got %h required %h", getPkt(base + 1), {1'b0, 31'd30});
        end
        assertions++;
        if (getPkt(base + 2) !== {1'b1, 31'd48}) begin
            failures++;
            $display("[TB] FAIL basic_pkt2: got %h required %h", getPkt(base + 2), {1'b1, 31'd48});
        end
        assertions++;
        if (doneRiseCyc - lastValidCyc != FLUSH_CYC + 1) begin
            failures++;
            $display("[TB] FAIL basic_done_latency: got %0d required %0d",
                     doneRiseCyc - lastValidCyc, FLUSH_CYC + 1);
        end
        assertions++;
        if ({o_error, o_busy, o_byteReady, o_done} !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL basic_end_flags: err/busy/ready/done got %b required 0001",
                     {o_error, o_busy, o_byteReady, o_done});
        end
        assertions++;
        if (o_packet !== {1'b1, 31'd48}) begin
            failures++;
            $display("[TB] FAIL basic_packet_hold: got %h required %h", o_packet, {1'b1, 31'd48});
        end
    endtask

    task automatic test_no_newline();
        int base;
        base = pktQ.size();
        startRun();
        assertions++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL nonl_done_clear: got %b required 0", o_done);
        end
        sendBytes("R1000", 1'b0, 1'b1);
        waitDone("nonl");
        assertions++;
        if ((pktQ.size() - base != 1) || (getPkt(base) !== {1'b1, 31'd1000})) begin
            failures++;
            $display("[TB] FAIL nonl_pkt: count %0d pkt %h required 1 %h",
                     pktQ.size() - base, getPkt(base), {1'b1, 31'd1000});
        end
        assertions++;
        if (doneRiseCyc - lastValidCyc != FLUSH_CYC + 1) begin
            failures++;
            $display("[TB] FAIL nonl_done_latency: got %0d required %0d",
                     doneRiseCyc - lastValidCyc, FLUSH_CYC + 1);
        end
    endtask

    task automatic test_malformed();
        int base;
        base = pktQ.size();
        startRun();
        sendBytes("L5\nX9\n\nR7\n", 1'b0, 1'b1);
        waitDone("malformed");
        assertions++;
        if (pktQ.size() - base != 2) begin
            failures++;
            $display("[TB] FAIL malformed_pkt_count: got %0d required 2", pktQ.size() - base);
        end
        assertions++;
        if ((getPkt(base) !== {1'b0, 31'd5}) || (getPkt(base + 1) !== {1'b1, 31'd7})) begin
            failures++;
            $display("[TB] FAIL malformed_pkts: got %h %h required %h %h",
                     getPkt(base), getPkt(base + 1), {1'b0, 31'd5}, {1'b1, 31'd7});
        end
        assertions++;
        if (o_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL malformed_error: got %b required 1", o_error);
        end
`ifdef DIAL_SEQ_STATS_EN
        assertions++;
        if ((o_lineCount !== 32'd2) || (o_discardCount !== 16'd1)) begin
            failures++;
            $display("[TB] FAIL malformed_stats: lines %0d discards %0d required 2 1",
                     o_lineCount, o_discardCount);
        end
`endif
    endtask

    task automatic test_saturation();
        int base;
        base = pktQ.size();
        startRun();
        assertions++;
        if (o_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sat_error_clear: got %b required 0", o_error);
        end
        sendBytes("R99999999999\n", 1'b0, 1'b1);
        waitDone("sat");
        assertions++;
        if ((pktQ.size() - base != 1) || (getPkt(base) !== 32'hFFFF_FFFF)) begin
            failures++;
            $display("[TB] FAIL sat_pkt: count %0d pkt %h required 1 ffffffff",
                     pktQ.size() - base, getPkt(base));
        end
        assertions++;
        if (o_error !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sat_error: got %b required 1", o_error);
        end
    endtask

    task automatic test_crlf_gaps();
        int base;
        base = pktQ.size();
        startRun();
        sendBytes("L2\r\nR3\r\n", 1'b1, 1'b1);
        waitDone("crlf");
        assertions++;
        if (pktQ.size() - base != 2) begin
            failures++;
            $display("[TB] FAIL crlf_pkt_count: got %0d required 2", pktQ.size() - base);
        end
        assertions++;
        if ((getPkt(base) !== {1'b0, 31'd2}) || (getPkt(base + 1) !== {1'b1, 31'd3})) begin
            failures++;
            $display("[TB] FAIL crlf_pkts: got %h %h required %h %h",
                     getPkt(base), getPkt(base + 1), {1'b0, 31'd2}, {1'b1, 31'd3});
        end
        assertions++;
        if ((o_error !== 1'b0) || (adjacentPulses != 0)) begin
            failures++;
            $display("[TB] FAIL crlf_flags: error %b adjacent %0d required 0 0", o_error, adjacentPulses);
        end
    endtask

    task automatic test_reset_midrun();
        int base, rbase;
        startRun();
        sendBytes("R12X", 1'b0, 1'b0);
        assertions++;
        if ((o_error !== 1'b1) || (o_busy !== 1'b1)) begin
            failures++;
            $display("[TB] FAIL midrun_pre: error %b busy %b required 1 1", o_error, o_busy);
        end
        sendBytes("R12", 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        assertions++;
        if ({o_byteReady, o_procRst, o_dataValid, o_busy, o_done, o_error} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_flags: got %b required 000000",
                     {o_byteReady, o_procRst, o_dataValid, o_busy, o_done, o_error});
        end
        assertions++;
        if (o_packet !== 32'h0) begin
            failures++;
            $display("[TB] FAIL midrun_reset_packet: got %h required 00000000", o_packet);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = pktQ.size(); rbase = rstPulses;
        startRun();
        sendBytes("\nL4\n", 1'b0, 1'b1);
        waitDone("midrun");
        assertions++;
        if (rstPulses - rbase != 1) begin
            failures++;
            $display("[TB] FAIL midrun_procrst_count: got %0d required 1", rstPulses - rbase);
        end
        assertions++;
        if ((pktQ.size() - base != 1) || (getPkt(base) !== {1'b0, 31'd4})) begin
            failures++;
            $display("[TB] FAIL midrun_pkt: count %0d pkt %h required 1 %h",
                     pktQ.size() - base, getPkt(base), {1'b0, 31'd4});
        end
        assertions++;
        if (o_error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrun_error: got %b required 0", o_error);
        end
    endtask

    // Test sequence
    initial begin
        assertions = 0;
        failures   = 0;
        test_reset();
        test_basic();
        test_no_newline();
        test_malformed();
        test_saturation();
        test_crlf_gaps();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
